// File: rtl/rms_window_feeder.sv
// Squares and accumulates signed samples over a 2^LOG2_WIN window, hands the mean square
// to the iterative square-root engine and captures its root as the window RMS.
module rms_window_feeder #(
   parameter int SAMPLE_W = 16,
   parameter int LOG2_WIN = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic signed [SAMPLE_W-1:0] in_data,
   output logic                       in_ready,
   output logic [31:0]                ms_out,
   output logic                       sq_start,
   input  logic                       sq_rdy,
   input  logic [15:0]                sq_result,
   output logic [15:0]                rms_out,
   output logic                       rms_valid,
   output logic                       win_done,
   output logic                       busy
);

   localparam int ACC_W = 2*SAMPLE_W + LOG2_WIN;

   typedef enum logic [1:0] {S_IDLE, S_START, S_GUARD, S_WAIT} state_t;

   state_t                       r_state;
   state_t                       w_next;
   logic                         w_busy;

   logic        [ACC_W-1:0]      r_acc;
   logic        [LOG2_WIN-1:0]   r_cnt;
   logic        [31:0]           r_ms;
   logic        [15:0]           r_rms;
   logic                         r_rms_valid;
   logic                         r_win_done;
   logic                         r_sq_start;

   logic signed [2*SAMPLE_W-1:0] w_prod;
   logic        [2*SAMPLE_W-1:0] w_sq;
   logic        [ACC_W-1:0]      w_sum;
   logic                         w_last;
   logic                         w_accept;
   logic                         w_close;
   logic                         w_capture;

   // Mean square of the full window sum; clamps if the quotient needs more than 32 bits.
   function automatic logic [31:0] sat_ms(input logic [ACC_W-1:0] sum);
      logic [ACC_W+31:0] v;
      v = {32'd0, sum};
      v = v >> LOG2_WIN;
      if (|v[ACC_W+31:32])
         return 32'hFFFF_FFFF;
      return v[31:0];
   endfunction

   assign w_prod    = in_data * in_data;
   assign w_sq      = $unsigned(w_prod);
   assign w_sum     = r_acc + {{LOG2_WIN{1'b0}}, w_sq};
   assign w_last    = &r_cnt;
   // The closing sample is held off while the previous root is still pending.
   assign in_ready  = !(w_busy && w_last);
   assign w_accept  = in_valid && in_ready;
   assign w_close   = w_accept && w_last;
   assign w_capture = (r_state == S_WAIT) && sq_rdy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (w_close)
               w_next = S_START;
         end
         S_START: w_next = S_GUARD;
         // Ready from a previous result may still be high here; it is not trusted.
         S_GUARD: w_next = S_WAIT;
         S_WAIT: begin
            if (sq_rdy)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ms        <= '0;
         r_rms       <= '0;
         r_rms_valid <= 1'b0;
         r_win_done  <= 1'b0;
         r_sq_start  <= 1'b0;
      end else begin
         r_win_done  <= w_close;
         // Dedicated flop: this pulse feeds the engine's asynchronous reset.
         r_sq_start  <= w_close;
         r_rms_valid <= w_capture;
         if (w_capture)
            r_rms <= sq_result;
         if (w_accept) begin
            if (w_last) begin
               r_acc <= '0;
               r_cnt <= '0;
               r_ms  <= sat_ms(w_sum);
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign ms_out    = r_ms;
   assign sq_start  = r_sq_start;
   assign rms_out   = r_rms;
   assign rms_valid = r_rms_valid;
   assign win_done  = r_win_done;
   assign busy      = w_busy;

endmodule

// File: tb/tb_rms_window_feeder.sv
// Bench for rms_window_feeder: two instances (256- and 4-sample windows), each paired with
// a behavioural 16-iteration square-root engine; scoreboard queues hold expected results.
module tb_rms_window_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic               v8, v2;
   logic signed [15:0] d8, d2;
   logic               ir8, ir2, st8, st2, rv8, rv2, wd8, wd2, b8, b2;
   logic        [31:0] ms8, ms2;
   logic        [15:0] rms8, rms2;
   logic               mr8, mr2, stale2, sr2;
   logic        [15:0] res8, res2;
   logic        [31:0] x8, x2;
   int                 it8, it2;

   assign sr2 = mr2 | stale2;

   rms_window_feeder #(.SAMPLE_W(16), .LOG2_WIN(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(v8), .in_data(d8), .in_ready(ir8),
      .ms_out(ms8), .sq_start(st8), .sq_rdy(mr8), .sq_result(res8),
      .rms_out(rms8), .rms_valid(rv8), .win_done(wd8), .busy(b8));

   rms_window_feeder #(.SAMPLE_W(16), .LOG2_WIN(2)) dut2 (
      .clk(clk), .reset(reset), .in_valid(v2), .in_data(d2), .in_ready(ir2),
      .ms_out(ms2), .sq_start(st2), .sq_rdy(sr2), .sq_result(res2),
      .rms_out(rms2), .rms_valid(rv2), .win_done(wd2), .busy(b2));

   function automatic int isqrt(input longint x);
      int r;
      longint t;
      r = 0;
      for (int b = 15; b >= 0; b--) begin
         t = longint'(r | (1 << b));
         if (t * t <= x)
            r = r | (1 << b);
      end
      return r;
   endfunction

   // Engine model: held in reset by sq_start, ready after 16 iterations, ready window 16 cycles.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         it8 <= 32; mr8 <= 1'b0; res8 <= '0; x8 <= '0;
      end else if (st8) begin
         it8 <= 0; mr8 <= 1'b0; x8 <= ms8;
      end else if (it8 < 32) begin
         it8 <= it8 + 1;
         if (it8 == 15) begin mr8 <= 1'b1; res8 <= 16'(isqrt(longint'(x8))); end
         if (it8 == 31) mr8 <= 1'b0;
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         it2 <= 32; mr2 <= 1'b0; res2 <= '0; x2 <= '0;
      end else if (st2) begin
         it2 <= 0; mr2 <= 1'b0; x2 <= ms2;
      end else if (it2 < 32) begin
         it2 <= it2 + 1;
         if (it2 == 15) begin mr2 <= 1'b1; res2 <= 16'(isqrt(longint'(x2))); end
         if (it2 == 31) mr2 <= 1'b0;
      end
   end

   int     n_cmp = 0;
   int     n_err = 0;
   longint exp_ms[$];
   int     exp_wd_cyc[$];
   int     exp_rms[$];
   int     exp_rv_cyc[$];
   int     close_cyc[$];
   int     stim[$];
   longint m_sum;
   int     m_cnt;
   int     stalls;

   // idx: 0 ms_out, 1 rms_out, 2 rms_valid, 3 win_done, 4 sq_start, 5 busy, 6 in_ready
   function automatic logic [31:0] obs(input int w, input int idx);
      case (idx)
         0: return w != 0 ? ms2 : ms8;
         1: return {16'd0, (w != 0 ? rms2 : rms8)};
         2: return {31'd0, (w != 0 ? rv2 : rv8)};
         3: return {31'd0, (w != 0 ? wd2 : wd8)};
         4: return {31'd0, (w != 0 ? st2 : st8)};
         5: return {31'd0, (w != 0 ? b2 : b8)};
         6: return {31'd0, (w != 0 ? ir2 : ir8)};
         default: return 32'd0;
      endcase
   endfunction

   task automatic drive(input int w, input logic vin, input int s);
      if (w != 0) begin v2 = vin; d2 = 16'(s); end
      else        begin v8 = vin; d8 = 16'(s); end
   endtask

   task automatic clear_model();
      m_sum = 0; m_cnt = 0;
      exp_ms.delete(); exp_wd_cyc.delete(); exp_rms.delete(); exp_rv_cyc.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      clear_model();
   endtask

   task automatic feed(input int w);
      int s, k, lg, guard;
      longint ms;
      lg = (w != 0) ? 2 : 8;
      while (stim.size() > 0) begin
         s = stim.pop_front();
         @(negedge clk);
         drive(w, 1'b1, s);
         guard = 0;
         while (obs(w, 6) == 0) begin
            stalls++;
            guard++;
            if (guard > 200) begin
               n_cmp++; n_err++;
               $display("FAIL in_ready stuck low: dut%0d waited %0d cycles, required release", w, guard);
               drive(w, 1'b0, 0);
               stim.delete();
               return;
            end
            @(negedge clk);
         end
         k = cyc;
         @(posedge clk);
         m_sum += longint'(s) * longint'(s);
         m_cnt++;
         if (m_cnt == (1 << lg)) begin
            ms = m_sum >> lg;
            if (ms > 64'hFFFF_FFFF) ms = 64'hFFFF_FFFF;
            exp_ms.push_back(ms);
            exp_wd_cyc.push_back(k + 1);
            exp_rms.push_back(isqrt(ms));
            exp_rv_cyc.push_back(k + 19);
            close_cyc.push_back(k + 1);
            m_sum = 0;
            m_cnt = 0;
         end
      end
      @(negedge clk);
      drive(w, 1'b0, 0);
   endtask

   task automatic watch(input int w, input int ncyc);
      int n_st, n_wd, e_c, e_r;
      logic prev_st, prev_wd;
      longint e_ms;
      n_st = 0; n_wd = 0; prev_st = 1'b0; prev_wd = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (obs(w, 4) == 1) begin
            n_st++;
            n_cmp++;
            if (prev_st) begin
               n_err++;
               $display("FAIL sq_start width: dut%0d high again at cycle %0d, required one cycle", w, cyc);
            end
         end
         if (obs(w, 3) == 1) begin
            n_wd++;
            n_cmp++;
            if (prev_wd) begin
               n_err++;
               $display("FAIL win_done width: dut%0d high again at cycle %0d, required one cycle", w, cyc);
            end
            if (exp_ms.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL win_done unexpected: dut%0d ms_out=%0h cycle %0d, none pending", w, obs(w, 0), cyc);
            end else begin
               e_ms = exp_ms.pop_front();
               e_c  = exp_wd_cyc.pop_front();
               n_cmp++;
               if (obs(w, 0) !== e_ms[31:0]) begin
                  n_err++;
                  $display("FAIL ms_out: dut%0d got %0h required %0h", w, obs(w, 0), e_ms[31:0]);
               end
               n_cmp++;
               if (cyc != e_c) begin
                  n_err++;
                  $display("FAIL win_done timing: dut%0d cycle %0d required %0d", w, cyc, e_c);
               end
            end
         end
         if (obs(w, 2) == 1) begin
            if (exp_rms.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL rms_valid unexpected: dut%0d rms_out=%0h cycle %0d, none pending", w, obs(w, 1), cyc);
            end else begin
               e_r = exp_rms.pop_front();
               e_c = exp_rv_cyc.pop_front();
               n_cmp++;
               if (obs(w, 1) !== 32'(e_r)) begin
                  n_err++;
                  $display("FAIL rms_out: dut%0d got %0h required %0h", w, obs(w, 1), e_r);
               end
               n_cmp++;
               if (cyc != e_c) begin
                  n_err++;
                  $display("FAIL rms_valid timing: dut%0d cycle %0d required %0d", w, cyc, e_c);
               end
            end
         end
         prev_st = obs(w, 4)[0];
         prev_wd = obs(w, 3)[0];
      end
      n_cmp++;
      if (n_st != n_wd) begin
         n_err++;
         $display("FAIL sq_start count: dut%0d %0d pulses, required %0d (one per window)", w, n_st, n_wd);
      end
      n_cmp++;
      if (exp_ms.size() != 0 || exp_rms.size() != 0) begin
         n_err++;
         $display("FAIL missing outputs: dut%0d %0d ms and %0d rms still pending, required 0",
                  w, exp_ms.size(), exp_rms.size());
      end
      clear_model();
   endtask

   task automatic test_reset();
      logic [31:0] e;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      for (int w = 0; w < 2; w++) begin
         for (int idx = 0; idx < 7; idx++) begin
            e = (idx == 6) ? 32'd1 : 32'd0;
            n_cmp++;
            if (obs(w, idx) !== e) begin
               n_err++;
               $display("FAIL reset state: dut%0d output %0d got %0h required %0h", w, idx, obs(w, idx), e);
            end
         end
      end
      clear_model();
   endtask

   task automatic test_const_pos();
      repeat (256) stim.push_back(100);
      fork
         feed(0);
         watch(0, 300);
      join
   endtask

   task automatic test_min_neg();
      repeat (256) stim.push_back(-32768);
      fork
         feed(0);
         watch(0, 300);
      join
   endtask

   task automatic test_trunc();
      stim = '{1, 1, 1, 2};
      fork
         feed(1);
         watch(1, 40);
      join
   endtask

   task automatic test_stale_rdy();
      stim = '{3, -3, 3, -3};
      stale2 = 1'b1;
      fork
         begin
            feed(1);
            @(posedge clk);
            @(posedge clk);
            #1 stale2 = 1'b0;
         end
         watch(1, 40);
      join
   endtask

   task automatic test_back_to_back();
      close_cyc.delete();
      stalls = 0;
      stim = '{1, 2, 3, 4, 5, 6, 7, 8};
      fork
         feed(1);
         watch(1, 70);
      join
      n_cmp++;
      if (close_cyc.size() != 2) begin
         n_err++;
         $display("FAIL back_to_back windows: got %0d closes required 2", close_cyc.size());
      end else if (close_cyc[1] - close_cyc[0] != 19) begin
         n_err++;
         $display("FAIL back_to_back close spacing: got %0d required 19", close_cyc[1] - close_cyc[0]);
      end
      n_cmp++;
      if (stalls != 15) begin
         n_err++;
         $display("FAIL back_to_back stalls: got %0d required 15", stalls);
      end
   endtask

   task automatic test_reset_mid();
      repeat (100) stim.push_back(7);
      feed(0);
      do_reset();
      repeat (256) stim.push_back(10);
      fork
         feed(0);
         watch(0, 300);
      join
      stim = '{5, 5, 5, 5};
      feed(1);
      repeat (6) @(negedge clk);
      do_reset();
      #1;
      n_cmp++;
      if (obs(1, 1) !== 32'd0 || obs(1, 5) !== 32'd0) begin
         n_err++;
         $display("FAIL abort reset: rms_out=%0h busy=%0h required 0 0", obs(1, 1), obs(1, 5));
      end
      watch(1, 30);
   endtask

   initial begin
      reset = 1'b1;
      v8 = 1'b0; v2 = 1'b0; d8 = '0; d2 = '0; stale2 = 1'b0;
      m_sum = 0; m_cnt = 0; stalls = 0;
      test_reset();
      test_const_pos();
      test_min_neg();
      test_trunc();
      test_stale_rdy();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
